// File: rtl/branch_resolver_if.sv
// Branch resolver bus: prediction issue, resolution, predictor training
// and status/statistics outputs. master = core side, slave = resolver.
interface branch_resolver_if;
  logic        pred_valid;
  logic        pred_taken;
  logic        resolve_valid;
  logic        actual_taken;
  logic        update_valid;
  logic        update_taken;
  logic        mispredict;
  logic        full;
  logic        empty;
  logic [3:0]  occupancy;
  logic [15:0] mispredict_count;
  logic [15:0] resolved_count;
  logic        error;

  modport master (
    output pred_valid, pred_taken,
    output resolve_valid, actual_taken,
    input  update_valid, update_taken,
    input  mispredict, full, empty,
    input  occupancy, mispredict_count,
    input  resolved_count, error
  );

  modport slave (
    input  pred_valid, pred_taken,
    input  resolve_valid, actual_taken,
    output update_valid, update_taken,
    output mispredict, full, empty,
    output occupancy, mispredict_count,
    output resolved_count, error
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: circular FIFO of in-flight predictions, training strobe,
// mispredict flush and counters. Ports: clk, rst (sync high), bus (slave).
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  branch_resolver_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [3:0]    occ;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf;
  logic          udf;
  logic          miss;

  logic          upd_v;
  logic          upd_t;
  logic          mis_p;
  logic [15:0]   mis_cnt;
  logic [15:0]   res_cnt;
  logic          err;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occ == 4'(DEPTH));
  assign empty = (occ == 4'd0);

  always_comb begin
    push = bus.pred_valid && !full;
    ovf  = bus.pred_valid && full;
    pop  = bus.resolve_valid && !empty;
    udf  = bus.resolve_valid && empty;
    miss = pop && (mem[head] != bus.actual_taken);
  end

  // Storage is never reset; it is only read while occupied.
  always_ff @(posedge clk) begin
    if (!rst && push && !miss)
      mem[tail] <= bus.pred_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (miss) begin
      // Flush: younger entries and any same-cycle push are wrong-path.
      head <= tail;
      occ  <= '0;
    end else begin
      if (push)
        tail <= nxt(tail);
      if (pop)
        head <= nxt(head);
      occ <= occ + {3'b0, push} - {3'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_v   <= 1'b0;
      upd_t   <= 1'b0;
      mis_p   <= 1'b0;
      mis_cnt <= '0;
      res_cnt <= '0;
      err     <= 1'b0;
    end else begin
      upd_v <= pop;
      mis_p <= miss;
      if (pop)
        upd_t <= bus.actual_taken;
      if (pop && res_cnt != 16'hFFFF)
        res_cnt <= res_cnt + 16'd1;
      if (miss && mis_cnt != 16'hFFFF)
        mis_cnt <= mis_cnt + 16'd1;
      if (ovf || udf)
        err <= 1'b1;
    end
  end

  assign bus.update_valid     = upd_v;
  assign bus.update_taken     = upd_t;
  assign bus.mispredict       = mis_p;
  assign bus.full             = full;
  assign bus.empty            = empty;
  assign bus.occupancy        = occ;
  assign bus.mispredict_count = mis_cnt;
  assign bus.resolved_count   = res_cnt;
  assign bus.error            = err;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed steps plus a random phase,
// checked against a queue model through an expected-result scoreboard.
module tb_branch_resolver;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic uv;
    logic ut;
    logic mp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_resolver_if bus ();

  branch_resolver #(
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nchk  = 0;
  int npass = 0;

  bit          mq[$];
  exp_t        sb[$];
  logic [15:0] m_res = '0;
  logic [15:0] m_mis = '0;
  logic        m_err = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic chk_state();
    chk("occupancy", bus.occupancy, 16'(mq.size()));
    chk("full", bus.full, 16'(mq.size() == DEPTH));
    chk("empty", bus.empty, 16'(mq.size() == 0));
    chk("resolved_count", bus.resolved_count, m_res);
    chk("mispredict_count", bus.mispredict_count, m_mis);
    chk("error", bus.error, 16'(m_err));
  endtask

  task automatic step(
    input logic pv,
    input logic pt,
    input logic rv,
    input logic at
  );
    exp_t e;
    bit   fm;
    bit   em;
    bit   p;
    bus.pred_valid    = pv;
    bus.pred_taken    = pt;
    bus.resolve_valid = rv;
    bus.actual_taken  = at;
    fm = (mq.size() == DEPTH);
    em = (mq.size() == 0);
    e  = '0;
    if (rv) begin
      if (em) begin
        m_err = 1'b1;
      end else begin
        p    = mq.pop_front();
        e.uv = 1'b1;
        e.ut = at;
        e.mp = (p != at);
        if (m_res != 16'hFFFF) m_res++;
        if (e.mp && m_mis != 16'hFFFF) m_mis++;
      end
    end
    if (pv) begin
      if (fm) m_err = 1'b1;
      else if (!e.mp) mq.push_back(pt);
    end
    if (e.mp) mq.delete();
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("update_valid", bus.update_valid, 16'(e.uv));
    chk("mispredict", bus.mispredict, 16'(e.mp));
    if (e.uv)
      chk("update_taken", bus.update_taken, 16'(e.ut));
    chk_state();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_step(input logic pv, input logic rv);
    rst               = 1'b1;
    bus.pred_valid    = pv;
    bus.pred_taken    = 1'b1;
    bus.resolve_valid = rv;
    bus.actual_taken  = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    mq.delete();
    sb.delete();
    m_res = '0;
    m_mis = '0;
    m_err = 1'b0;
    chk("rst_update_valid", bus.update_valid, 16'd0);
    chk("rst_update_taken", bus.update_taken, 16'd0);
    chk("rst_mispredict", bus.mispredict, 16'd0);
    chk_state();
  endtask

  initial begin
    bit at;
    bus.pred_valid    = 1'b0;
    bus.pred_taken    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.actual_taken  = 1'b0;

    rst_step(1'b0, 1'b0);
    idle();

    // Correct predictions T,N,T
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    idle();
    step(0, 0, 1, 1);
    idle();
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    idle();

    // Mispredict flush
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle();

    // Overflow on a fifth push
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    idle();

    // Underflow resolve
    rst_step(1'b0, 1'b0);
    step(0, 0, 1, 1);
    idle();

    // Push and correct resolve at occupancy 1, then a mispredict
    // that also drops a same-cycle push
    rst_step(1'b0, 1'b0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    idle();

    // Steady occupancy 2 with pointer wrap
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, 1'($urandom_range(0, 1)), 1, mq[0]);
    step(0, 0, 1, mq[0]);
    step(0, 0, 1, mq[0]);
    idle();

    // Reset mid-operation with both strobes high
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    rst_step(1'b1, 1'b1);
    idle();

    // Random traffic, mostly correct resolves
    for (int i = 0; i < 300; i++) begin
      if (mq.size() != 0 && $urandom_range(0, 3) != 0)
        at = mq[0];
      else
        at = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0),
           at);
    end
    idle();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
